// File: rtl/stack_cmd_sequencer.sv
// Request/response front end for the structural stack: screens each operation against
// occupancy, issues a single COMMAND/INDEX cycle, and owns the shared stack data bus.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; error check done at the accept edge
//   EXEC  | one cycle of stack command; PUSH drives the data bus
//   RESP  | response held until the consumer takes it
module stack_cmd_sequencer #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [2:0]       REQ_INDEX,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic             RSP_ERR,
    output logic [2:0]       COUNT,
    output logic [1:0]       STK_COMMAND,
    output logic [2:0]       STK_INDEX,
    inout  wire  [WIDTH-1:0] STK_DATA
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_GET  = 2'b11;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             drive_q;
    logic [WIDTH-1:0] data_q;
    logic             req_err;

    always_comb begin
        req_err = 1'b0;
        case (REQ_OP)
            OP_PUSH: req_err = (COUNT == DEPTH_C);
            OP_POP:  req_err = (COUNT == 3'd0);
            OP_GET:  req_err = (REQ_INDEX >= COUNT);
            default: req_err = 1'b0;
        endcase
    end

    assign REQ_READY = (state == IDLE) && !RESET;

    // The bus is only ever driven during the EXEC cycle of a PUSH.
    assign STK_DATA = drive_q ? data_q : {WIDTH{1'bz}};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            COUNT       <= 3'd0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
            RSP_ERR     <= 1'b0;
            STK_COMMAND <= OP_NOP;
            STK_INDEX   <= 3'd0;
            drive_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        RSP_DATA <= '0;
                        if (req_err) begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                        end else begin
                            state       <= EXEC;
                            RSP_ERR     <= 1'b0;
                            STK_COMMAND <= REQ_OP;
                            STK_INDEX   <= (REQ_OP == OP_GET) ? REQ_INDEX : 3'd0;
                            drive_q     <= (REQ_OP == OP_PUSH);
                            data_q      <= REQ_DATA;
                        end
                    end
                end
                EXEC: begin
                    // STK_COMMAND still holds the op being executed this cycle.
                    if (STK_COMMAND == OP_POP || STK_COMMAND == OP_GET)
                        RSP_DATA <= STK_DATA;
                    if (STK_COMMAND == OP_PUSH)
                        COUNT <= COUNT + 3'd1;
                    else if (STK_COMMAND == OP_POP)
                        COUNT <= COUNT - 3'd1;
                    STK_COMMAND <= OP_NOP;
                    STK_INDEX   <= 3'd0;
                    drive_q     <= 1'b0;
                    RSP_VALID   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
